pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline-stage register, successor to the fixed two-field W-stage register.
//  Carries NUM_FIELDS fields of DATA_W bits with a valid/ready handshake and a 2-entry skid buffer.
//  Also provides stop (freeze) and flush (squash). Sits between any two CPU pipeline stages.
//  in_ready is registered, so there is no combinational out_ready->in_ready path; full throughput.
// PARAMETERS
//  DATA_W      32  width of one field
//  NUM_FIELDS  2   number of fields packed in in_data/out_data (field k = bits [k*DATA_W +: DATA_W])
//  RESET_VAL   0   per-field reset value of out_data (DATA_W bits, replicated per field)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  stop       in   1                  freeze whole stage (cache miss / not ready)
//  flush      in   1                  squash stage contents (branch/exception)
//  in_valid   in   1                  upstream data valid
//  in_ready   out  1                  stage can accept in_data this cycle
//  in_data    in   NUM_FIELDS*DATA_W  upstream fields
//  out_valid  out  1                  out_data valid
//  out_ready  in   1                  downstream accepts out_data this cycle
//  out_data   out  NUM_FIELDS*DATA_W  registered fields (main register)
//  stall_cnt  out  32                 [STAGE_STATS_EN only] saturating stall-cycle count
//  xfer_cnt   out  32                 [STAGE_STATS_EN only] saturating output-transfer count
// BEHAVIOUR
//  Reset (async): state=ST_EMPTY; main and skid registers = RESET_VAL per field; out_valid=0; in_ready=1 (stop=0).
//  Accept = in_valid & in_ready; Transfer = out_valid & out_ready. Priority: rst > stop > flush > normal.
//  Combinational masks: in_ready = (state!=ST_FULL) & ~stop; out_valid = (state!=ST_EMPTY) & ~stop.
//  FSM (normal operation):
//   ST_EMPTY: accept -> main<=in_data, ST_BUSY; else hold.
//   ST_BUSY : accept & transfer  -> main<=in_data, stay.
//             accept & ~transfer -> skid<=in_data, ST_FULL.
//             ~accept & transfer -> ST_EMPTY.
//             neither            -> hold.
//   ST_FULL : transfer -> main<=skid, ST_BUSY (in_ready=0, so no accept); else hold.
//  Latency: 1 cycle from accept to out_valid. Throughput: 1 item/cycle, with no bubble while out_ready is held high.
//  Order: items leave in acceptance order. The skid entry is never overwritten while ST_FULL.
//  stop=1: all registers hold; in_ready=0 and out_valid=0 that cycle, so no handshake occurs.
//   out_data is unchanged. Deasserting stop resumes from the frozen state.
//  flush=1 (stop=0): next state ST_EMPTY; any input presented that cycle is discarded, even if accepted.
//   Data registers are not cleared (don't-care while invalid).
//  stop & flush together: stop wins; the flush is lost (the requester must hold it).
//  Reset mid-operation: all contents dropped immediately; the state is as after reset.
//  out_data always reflects the main register, even when out_valid=0.
// CONFIGURATION
//  Macro STAGE_STATS_EN:
//   Defined: stall_cnt and xfer_cnt ports exist.
//    stall_cnt += 1 each cycle with (state!=ST_EMPTY) & ~out_ready & ~stop.
//    xfer_cnt += 1 on each transfer.
//    Both saturate at 32'hFFFF_FFFF, are cleared only by rst, and are not affected by flush.
//   Undefined: ports and counters are absent; datapath and FSM are identical.
// STRUCTURE
//  Package pipe_stage_pkg: typedef enum logic[1:0] {ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2} stage_state_t;
//   localparam STAT_W=32.
//  Sub-module pipe_sat_counter (WIDTH, inc, rst, clk, count): instantiated twice under STAGE_STATS_EN.
//  The rest (FSM, main/skid registers) stays inline in pipe_stage_skid.
// TESTING (DATA_W=32, NUM_FIELDS=2, RESET_VAL=0 unless stated)
//  1. Reset
//     rst pulse mid-cycle (async) -> out_valid=0, in_ready=1, out_data=64'h0 immediately, before the next edge.
//  2. Streaming
//     in_valid=1 with data 1..8 on consecutive cycles, out_ready=1
//     -> out_data 1..8 on cycles 1..8 after the first accept, out_valid continuous, in_ready never drops.
//  3. Skid
//     BUSY with item A; present B with out_ready=0 -> ST_FULL, in_ready=0.
//     Raise out_ready -> A then B out on consecutive cycles; in_ready=1 after A leaves.
//  4. Stop
//     In ST_FULL, hold stop=1 for 5 cycles with out_ready=1
//     -> out_valid=0, in_ready=0, out_data unchanged, no items lost.
//     After release, both items delivered in order.
//  5. Flush
//     In ST_FULL, assert flush with in_valid=1, data=64'hDEAD
//     -> next cycle ST_EMPTY, out_valid=0, 64'hDEAD never appears with out_valid=1.
//     stop & flush together -> state unchanged.
//  6. Stats (STAGE_STATS_EN)
//     3 transfers and 4 blocked cycles -> xfer_cnt=3, stall_cnt=4.
//     Preload a counter to 32'hFFFF_FFFE, force 3 more increments -> counter holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
// The stage's three occupancy states and the width of the optional statistics counters live here.
package pipe_stage_pkg;

    // EMPTY: nothing held. BUSY: one item in the main register. FULL: main plus skid both hold items.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage statistics.
// It counts one per cycle while inc is high and sticks at all-ones instead of wrapping.
// Only the asynchronous reset clears it.
module pipe_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // The increment is suppressed at the ceiling so the count never wraps back to zero
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on the registered state and on stop, so there is no combinational out_ready->in_ready path.
// stop freezes the stage, and flush squashes its contents.
// Optional feature: define STAGE_STATS_EN to add saturating stall and transfer counters (stall_cnt, xfer_cnt).
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_FIELDS = 2,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stop,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data
`ifdef STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0]            stall_cnt,
    output logic [STAT_W-1:0]            xfer_cnt
`endif
);

    localparam int unsigned      W          = NUM_FIELDS * DATA_W;
    localparam logic [W-1:0]     RESET_WORD = {NUM_FIELDS{RESET_VAL}};

    stage_state_t state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    logic accept;
    logic transfer;

    // stop masks both handshake signals, so no accept or transfer can happen while the stage is frozen
    assign in_ready  = (state_q != ST_FULL)  & ~stop;
    assign out_valid = (state_q != ST_EMPTY) & ~stop;
    assign out_data  = main_q;

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;

    // Next-state logic: stop holds everything and flush empties the stage.
    // Otherwise the skid buffer absorbs one item when downstream stalls.
    // A flush leaves the data registers alone because their contents are don't-care once the stage is invalid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (stop) begin
            state_d = state_q;
        end else if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && transfer) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (transfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (transfer) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers; reset drops all contents immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_WORD;
            skid_q  <= RESET_WORD;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef STAGE_STATS_EN
    logic stallInc;
    logic xferInc;

    // A stall is an occupied, unfrozen stage that downstream refuses to take from
    assign stallInc = (state_q != ST_EMPTY) & ~out_ready & ~stop;
    assign xferInc  = transfer;

    pipe_sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stallInc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(STAT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (xferInc),
        .count (xfer_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid.
// It covers reset, streaming, the skid buffer, stop, flush and saturation, plus the stats counters under STAGE_STATS_EN.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_FIELDS = 2;
    localparam int unsigned W          = DATA_W * NUM_FIELDS;

    logic         clk;
    logic         rst;
    logic         stop;
    logic         flush;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inData;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;
`ifdef STAGE_STATS_EN
    logic [31:0]  stallCnt;
    logic [31:0]  xferCnt;
`endif

    logic         satInc;
    logic [1:0]   satCount;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .NUM_FIELDS (NUM_FIELDS),
        .RESET_VAL  ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData)
`ifdef STAGE_STATS_EN
        ,
        .stall_cnt (stallCnt),
        .xfer_cnt  (xferCnt)
`endif
    );

    // Narrow instance so that saturation is reached within a few cycles
    pipe_sat_counter #(.WIDTH(2)) satDut (
        .clk   (clk),
        .rst   (rst),
        .inc   (satInc),
        .count (satCount)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy,
                                 input logic st, input logic fl);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        stop     = st;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0; satInc = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_in_ready",  64'(inReady),  64'd1);
        checkOutput("rst_out_data",  outData,       64'h0);
        #9 rst = 1'b0;
        tick();

        // Streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("stream_in_ready_%0d", i), 64'(inReady), 64'd1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("stream_data_%0d", i),  outData,       64'(i));
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stream_drained", 64'(outValid), 64'd0);

        // Skid: A held in main, B lands in skid
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_busy_ready", 64'(inReady), 64'd1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_full_ready", 64'(inReady),  64'd0);
        checkOutput("skid_full_valid", 64'(outValid), 64'd1);
        checkOutput("skid_full_data",  outData,       64'hA);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("skid_b_data",  outData,       64'hB);
        checkOutput("skid_b_valid", 64'(outValid), 64'd1);
        checkOutput("skid_b_ready", 64'(inReady),  64'd1);
        tick();
        checkOutput("skid_empty", 64'(outValid), 64'd0);

        // Stop while FULL with C/D; an input offered during stop must not enter
        applyStimulus(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'hD, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'hEE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stop_valid_%0d", i), 64'(outValid), 64'd0);
            checkOutput($sformatf("stop_ready_%0d", i), 64'(inReady),  64'd0);
            checkOutput($sformatf("stop_data_%0d", i),  outData,       64'hC);
            tick();
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("stop_resume_valid", 64'(outValid), 64'd1);
        checkOutput("stop_resume_c",     outData,       64'hC);
        tick();
        checkOutput("stop_resume_d",     outData,       64'hD);
        checkOutput("stop_resume_d_vld", 64'(outValid), 64'd1);
        tick();
        checkOutput("stop_drained", 64'(outValid), 64'd0);

        // stop & flush together: stop wins, FULL is kept
        applyStimulus(1'b1, 64'h1E, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h1F, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("stopflush_valid", 64'(outValid), 64'd1);
        checkOutput("stopflush_ready", 64'(inReady),  64'd0);
        checkOutput("stopflush_data",  outData,       64'h1E);

        // Flush from FULL with DEAD offered
        applyStimulus(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_full_valid", 64'(outValid), 64'd0);
        checkOutput("flush_full_ready", 64'(inReady),  64'd1);
        tick();
        checkOutput("flush_full_after", 64'(outValid), 64'd0);

        // Flush from BUSY where DEAD is actually accepted, then discarded
        applyStimulus(1'b1, 64'h33, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_busy_ready", 64'(inReady), 64'd1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_busy_valid", 64'(outValid), 64'd0);
        tick();
        checkOutput("flush_busy_after", 64'(outValid), 64'd0);

        // Asynchronous reset mid-operation, checked before the next edge
        applyStimulus(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_data", outData, 64'h55);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(outValid), 64'd0);
        checkOutput("midrst_ready", 64'(inReady),  64'd1);
        checkOutput("midrst_data",  outData,       64'h0);
        #1 rst = 1'b0;
        tick();

`ifdef STAGE_STATS_EN
        // Stats: 4 blocked cycles with one item held, then 3 transfers
        checkOutput("stat_rst_stall", 64'(stallCnt), 64'd0);
        checkOutput("stat_rst_xfer",  64'(xferCnt),  64'd0);
        applyStimulus(1'b1, 64'h71, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(1'b1, 64'h72, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h73, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("stat_stall", 64'(stallCnt), 64'd4);
        checkOutput("stat_xfer",  64'(xferCnt),  64'd3);
`endif

        // Saturation on a 2-bit counter: 1, 2, 3, then stuck at 3
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        checkOutput("sat_reset", 64'(satCount), 64'd0);
        satInc = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("sat_step_%0d", i), 64'(satCount), 64'((i > 3) ? 3 : i));
        end
        satInc = 1'b0;
        tick();
        checkOutput("sat_hold", 64'(satCount), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
